// File: rtl/veda_mem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | veda_mem_arbiter_if : client command bus and memory pin bundle for         |
// |                       veda_mem_arbiter (two requesters, 32x32 memory).     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface veda_mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_we;
  logic            mem_mode;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_we, mem_mode, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_we, mem_mode, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/veda_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | veda_mem_arbiter : two-requester arbiter/sequencer for the 32x32 memory,   |
// |                    round-robin, or strict priority if                      |
// |                    VEDA_ARB_FIXED_PRIO_EN is defined.                      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module veda_mem_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  veda_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RW1  = 3'd3,
    RW2  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              id;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [NREQ-1:0]   gnt_r, gnt_nx;
  logic [NREQ-1:0]   done_r, done_nx;
  logic [DW-1:0]     rdata_r;
  logic              load_cmd;
  logic              win;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;

`ifdef VEDA_ARB_FIXED_PRIO_EN
  // Requester 0 always wins; requester 1 only gets the bus when 0 is quiet.
  assign win = ~bus.req[0];
`else
  logic ptr;
  // ptr names the tie winner; a lone requester wins regardless of ptr.
  assign win = (bus.req == 2'b11) ? ptr : ~bus.req[0];
`endif

  assign win_addr  = win ? bus.addr[2*AW-1:AW]  : bus.addr[AW-1:0];
  assign win_wdata = win ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];

  always_comb begin
    state_nx = state;
    gnt_nx   = '0;
    done_nx  = '0;
    load_cmd = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          load_cmd     = 1'b1;
          gnt_nx[win]  = 1'b1;
          state_nx     = bus.we[win] ? WR : RD;
        end
      end
      WR: begin
        done_nx[id] = 1'b1;
        state_nx    = IDLE;
      end
      RD:  state_nx = RW1;
      RW1: state_nx = RW2;
      RW2: begin
        done_nx[id] = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      id        <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      gnt_r     <= '0;
      done_r    <= '0;
      rdata_r   <= '0;
`ifndef VEDA_ARB_FIXED_PRIO_EN
      ptr       <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      gnt_r  <= gnt_nx;
      done_r <= done_nx;
      if (load_cmd) begin
        id        <= win;
        cmd_addr  <= win_addr;
        cmd_wdata <= win_wdata;
`ifndef VEDA_ARB_FIXED_PRIO_EN
        ptr       <= ~win;
`endif
      end
      // data_out has been through both memory pipeline stages by RW2
      if (state == RW2) rdata_r <= bus.mem_rdata;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.rdata     = rdata_r;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_mode  = 1'b1;
  assign bus.mem_we    = (state == WR);
  assign bus.mem_addr  = (state == WR || state == RD) ? cmd_addr  : '0;
  assign bus.mem_wdata = (state == WR || state == RD) ? cmd_wdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_veda_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_veda_mem_arbiter : directed bench with a transaction-timeline model     |
// |                       and a 2-stage memory model behind the arbiter.       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_veda_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 512;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  veda_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  veda_mem_arbiter #(.AW(AW), .DW(DW), .NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: intermediate register then data_out, both reset to zero
  logic [DW-1:0] mem_arr [32];
  logic [DW-1:0] mem_inter, mem_dout;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= '0;
      mem_inter <= '0;
      mem_dout  <= '0;
    end else begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      mem_inter <= bus.mem_mode ? mem_arr[bus.mem_addr] : bus.mem_wdata;
      mem_dout  <= mem_inter;
    end
  end
  assign bus.mem_rdata = mem_dout;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted command books its grant, busy span,
  // memory pins, done pulse and read result at absolute cycle indices.
  logic [1:0]    e_gnt  [N];
  logic [1:0]    e_done [N];
  logic          e_busy [N];
  logic          e_we   [N];
  logic [AW-1:0] e_addr [N];
  logic [DW-1:0] e_wd   [N];
  logic          e_rdv  [N];
  logic [DW-1:0] e_rdval[N];
  logic [DW-1:0] mm     [32];
  int            cyc = 0;
  int            next_free = 0;
  int            m_w, m_len;
  bit            m_ptr = 1'b0;
  logic          m_iswr;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        e_gnt[i] = '0; e_done[i] = '0; e_busy[i] = 1'b0; e_we[i] = 1'b0;
        e_addr[i] = '0; e_wd[i] = '0; e_rdv[i] = 1'b0; e_rdval[i] = '0;
      end
      for (int i = 0; i < 32; i++) mm[i] = '0;
      cyc = 0; next_free = 0; m_ptr = 1'b0;
    end else begin
      cyc++;
      if (cyc >= next_free && bus.req != 2'b00 && cyc + 4 < N) begin
`ifdef VEDA_ARB_FIXED_PRIO_EN
        m_w = bus.req[0] ? 0 : 1;
`else
        m_w = (bus.req == 2'b11) ? int'(m_ptr) : (bus.req[0] ? 0 : 1);
        m_ptr = (m_w == 0);
`endif
        m_iswr = bus.we[m_w];
        m_a    = (m_w == 1) ? bus.addr[2*AW-1:AW]  : bus.addr[AW-1:0];
        m_d    = (m_w == 1) ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
        m_len  = m_iswr ? 2 : 4;
        e_gnt[cyc]  = 2'b01 << m_w;
        e_addr[cyc] = m_a;
        e_wd[cyc]   = m_d;
        for (int k = 0; k < m_len - 1; k++) e_busy[cyc + k] = 1'b1;
        e_done[cyc + m_len - 1] = 2'b01 << m_w;
        if (m_iswr) begin
          e_we[cyc] = 1'b1;
          mm[m_a]   = m_d;
        end else begin
          e_rdv[cyc + 3]   = 1'b1;
          e_rdval[cyc + 3] = mm[m_a];
        end
        next_free = cyc + m_len;
      end
    end
  end

  logic [DW-1:0] m_rdata = '0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_rdata = '0;
      chk("rst_gnt",   64'(bus.gnt),   64'd0);
      chk("rst_done",  64'(bus.done),  64'd0);
      chk("rst_busy",  64'(bus.busy),  64'd0);
      chk("rst_rdata", 64'(bus.rdata), 64'd0);
    end else if (cyc < N) begin
      if (e_rdv[cyc]) m_rdata = e_rdval[cyc];
      chk("gnt",       64'(bus.gnt),       64'(e_gnt[cyc]));
      chk("done",      64'(bus.done),      64'(e_done[cyc]));
      chk("busy",      64'(bus.busy),      64'(e_busy[cyc]));
      chk("mem_we",    64'(bus.mem_we),    64'(e_we[cyc]));
      chk("mem_addr",  64'(bus.mem_addr),  64'(e_addr[cyc]));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wd[cyc]));
      chk("mem_mode",  64'(bus.mem_mode),  64'd1);
      chk("rdata",     64'(bus.rdata),     64'(m_rdata));
    end
  end

  logic [1:0]    gq[$];
  logic [1:0]    dq[$];
  logic [DW-1:0] rq[$];

  task automatic drive(input logic [1:0] r, input logic [1:0] w,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Write DEADBEEF to address 3 from requester 0
    @(negedge clk);
    drive(2'b01, 2'b01, 5'd0, 5'd3, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_gnt", 64'(bus.gnt), 64'h1);
    chk("t1_we", 64'(bus.mem_we), 64'h1);
    chk("t1_addr", 64'(bus.mem_addr), 64'd3);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    chk("t1_done", 64'(bus.done), 64'h1);
    chk("t1_we_off", 64'(bus.mem_we), 64'h0);

    // Read it back immediately
    drive(2'b01, 2'b00, 5'd0, 5'd3, '0, '0);
    @(negedge clk);
    chk("t2_gnt", 64'(bus.gnt), 64'h1);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("t2_nodone", 64'(bus.done), 64'h0);
    @(negedge clk);
    chk("t2_done", 64'(bus.done), 64'h1);
    chk("t2_rdata", 64'(bus.rdata), 64'hDEADBEEF);

    // Seed addr 1 and 2, then both requesters stream reads
    drive(2'b01, 2'b01, 5'd0, 5'd1, 32'h0, 32'hA1A10001);
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    drive(2'b10, 2'b10, 5'd2, 5'd0, 32'hB2B20002, 32'h0);
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    drive(2'b11, 2'b00, 5'd2, 5'd1, '0, '0);
    for (int i = 0; i < 24 && gq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) gq.push_back(bus.gnt);
      if (bus.done != 2'b00) begin dq.push_back(bus.done); rq.push_back(bus.rdata); end
    end
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin dq.push_back(bus.done); rq.push_back(bus.rdata); end
    end
    chk("t3_ngnt", 64'(gq.size()), 64'd4);
    chk("t3_ndone", 64'(dq.size()), 64'd4);
    if (gq.size() == 4 && dq.size() == 4) begin
`ifdef VEDA_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) begin
        chk("t3_gnt_seq", 64'(gq[i]), 64'h1);
        chk("t3_rdata", 64'(rq[i]), 64'hA1A10001);
      end
`else
      for (int i = 0; i < 4; i++) begin
        chk("t3_gnt_seq", 64'(gq[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
        chk("t3_done_seq", 64'(dq[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
        chk("t3_rdata", 64'(rq[i]), (i % 2 == 0) ? 64'hA1A10001 : 64'hB2B20002);
      end
`endif
    end

    // Reset while a read sits in RW1
    @(negedge clk);
    drive(2'b10, 2'b00, 5'd2, 5'd0, '0, '0);
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    chk("t6_busy_pre", 64'(bus.busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", 64'(bus.busy), 64'h0);
    chk("t6_gnt", 64'(bus.gnt), 64'h0);
    chk("t6_done", 64'(bus.done), 64'h0);
    chk("t6_rdata", 64'(bus.rdata), 64'h0);
    @(negedge clk); #2 reset = 1'b0;
    repeat (6) @(negedge clk);
    drive(2'b10, 2'b10, 5'd7, 5'd0, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("t6_regnt", 64'(bus.gnt), 64'h2);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    chk("t6_redone", 64'(bus.done), 64'h2);

    // Simultaneous first request after reset: requester 0 first
    do_reset();
    @(negedge clk);
    drive(2'b11, 2'b11, 5'd9, 5'd8, 32'h0BAD0009, 32'h0BAD0008);
    @(negedge clk);
    chk("t4_gnt0", 64'(bus.gnt), 64'h1);
    bus.req = 2'b10;
    @(negedge clk);
    chk("t4_done0", 64'(bus.done), 64'h1);
    @(negedge clk);
    chk("t4_gnt1", 64'(bus.gnt), 64'h2);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    drive(2'b01, 2'b00, 5'd0, 5'd9, '0, '0);
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("t4_rdata", 64'(bus.rdata), 64'h0BAD0009);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
